interrupt_vector_fetch: RTL and testbench
=========================================

Name: interrupt_vector_fetch

Overview:
Interrupt front-end feeding the pipeline's exception-memory (emem) port consumer path. Edge-detects 16 external interrupt lines, latches pending requests, picks the highest-priority one, and reads its handler address from the interrupt vector table over the emem request/response handshake. Presents {vector, handler} to the pipeline's exception logic over a valid/ready interface and clears the pending bit on acceptance.

Parameters:
NUM_INT, 16, number of interrupt lines (vector index width = 4)
IDT_BASE, 32'h0000_0400, byte address of vector table entry 0
ENTRY_SHIFT, 2, log2 bytes per table entry (4-byte entries)
ADDRW, 32, emem address width
DATAW, 32, emem read data / handler width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
interrupt  in  16  level interrupt lines, bit 0 highest priority
int_enable  in  1  pipeline IF flag; new selection only while 1
emem_valid  out  1  vector-table read request valid
emem_ready  in  1  memory accepts request
emem_address  out  32  IDT_BASE + (vec << ENTRY_SHIFT)
emem_wr_en  out  1  tied 0 (read only)
emem_wr_data  out  32  tied 0
emem_wr_size  out  8  constant 8'd4 (bytes requested)
emem_dp_valid  in  1  read data valid
emem_dp_ready  out  1  block accepts read data
emem_dp_read_data  in  32  handler address from table
int_valid  out  1  interrupt ready for pipeline
int_ready  in  1  pipeline accepts interrupt
int_vector  out  4  index of delivered interrupt
int_handler  out  32  handler address
int_pending  out  16  current pending register (debug/status)

Behaviour:
- Reset (reset==0, async): state IDLE; pending, prev_int, vec, handler = 0; all outputs 0 except emem_wr_size=4.
- Edge detect: prev_int <= interrupt each cycle. Rise = interrupt & ~prev_int. pending[i] <= 1 on rise; a level held high sets pending once only.
- Clear: pending[vec] <= 0 on int_valid & int_ready. Rise on same bit same cycle wins: bit stays 1.
- FSM states IDLE, REQ, WAIT, DELIVER (registered).
- IDLE: if int_enable & |pending -> vec <= lowest set index of pending; go REQ. Otherwise stay. Pending set in cycle k is first visible to IDLE in cycle k+1.
- REQ: emem_valid=1, emem_address = IDT_BASE + {vec, 2'b00} (32-bit, modulo 2^32, vec stable). On emem_ready -> WAIT. emem_valid held until ready; address constant while held.
- WAIT: emem_dp_ready=1. On emem_dp_valid: handler <= emem_dp_read_data; go DELIVER. Data arriving same cycle as request acceptance is not accepted (dp_ready low in REQ).
- DELIVER: int_valid=1, int_vector=vec, int_handler=handler, stable until int_ready. On int_ready -> clear pending[vec], IDLE.
- int_enable deasserting after IDLE does not abort an in-flight fetch; delivery completes.
- Higher-priority rise during REQ/WAIT/DELIVER does not preempt; it is selected on the next IDLE pass.
- Minimum latency rise->int_valid: 4 cycles with zero-wait memory (pending, REQ, WAIT, DELIVER). Back-to-back: one IDLE cycle between deliveries.
- Reset mid-operation: immediate return to IDLE; outstanding emem response is ignored (dp_ready=0).

Test Plan:
- Reset: hold reset=0 with interrupt=16'hFFFF -> all outputs 0, emem_wr_size=4, int_pending=0; release, lines already high with prev_int=0 -> pending=16'hFFFF next cycle.
- Single IRQ: int_enable=1, raise interrupt[3], zero-wait responder returning 32'h0000_0040 -> emem_address=32'h0000_040C, int_valid with int_vector=3, int_handler=32'h40 four cycles after rise; int_ready -> pending[3]=0.
- Priority: raise bits 5 and 2 same cycle -> bit 2 delivered first (address 32'h408), then bit 5 (address 32'h414); pending 0 after both.
- Stalls: emem_ready low 3 cycles, dp_valid delayed 2, int_ready delayed 5 -> emem_valid/address and int_valid/vector/handler stable throughout; exactly one request issued.
- Enable gating / clear-set collision: int_enable=0 with pending[1]=1 -> no emem_valid; enable, deliver, and re-raise interrupt[1] in the int_ready cycle -> pending[1] remains 1, second delivery follows.
- Reset during WAIT: assert reset=0 while waiting, then drive dp_valid -> state IDLE, no int_valid, pending=0.

Source files
------------

// File: rtl/interrupt_vector_fetch.sv
// -----------------------------------------------------------------------------
// interrupt_vector_fetch
//
// Interrupt front-end for the pipeline exception path. Sixteen external lines
// are edge-detected into a pending register. When the pipeline allows it, the
// lowest-numbered pending line is chosen and its handler address is read from
// the interrupt vector table over the emem request/response ports. The result
// {vector, handler} is offered to the exception logic, and the pending bit is
// cleared once the pipeline takes it.
//
// Ports
//   clk                clock, all state on the rising edge
//   reset              asynchronous reset, active low
//   interrupt          level interrupt lines, bit 0 is highest priority
//   int_enable         pipeline IF flag; a new selection starts only while 1
//   emem_valid/ready   vector-table read request handshake
//   emem_address       IDT_BASE + (vector << ENTRY_SHIFT)
//   emem_wr_en/data    write side, always 0 (read only)
//   emem_wr_size       bytes per table entry (constant)
//   emem_dp_valid/ready read-data handshake
//   emem_dp_read_data  handler address returned by the table
//   int_valid/ready    interrupt delivery handshake to the pipeline
//   int_vector         index of the delivered interrupt
//   int_handler        handler address of the delivered interrupt
//   int_pending        live pending register (status)
//   fsm_state          current controller state (debug)
//
// Handshake rule used on all three channels: a transfer happens on a rising
// edge where valid and ready are both 1. Once valid is raised it stays high,
// with its payload unchanged, until that transfer edge; ready may be asserted
// or dropped freely and never depends combinationally on valid.
// -----------------------------------------------------------------------------
module interrupt_vector_fetch #(
  parameter int                ADDRW       = 32,
  parameter int                DATAW       = 32,
  parameter int                NUM_INT     = 16,
  parameter logic [ADDRW-1:0]  IDT_BASE    = 32'h0000_0400,
  parameter int                ENTRY_SHIFT = 2,
  localparam int               VW          = $clog2(NUM_INT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] interrupt,
  input  logic               int_enable,
  output logic               emem_valid,
  input  logic               emem_ready,
  output logic [ADDRW-1:0]   emem_address,
  output logic               emem_wr_en,
  output logic [DATAW-1:0]   emem_wr_data,
  output logic [7:0]         emem_wr_size,
  input  logic               emem_dp_valid,
  output logic               emem_dp_ready,
  input  logic [DATAW-1:0]   emem_dp_read_data,
  output logic               int_valid,
  input  logic               int_ready,
  output logic [VW-1:0]      int_vector,
  output logic [DATAW-1:0]   int_handler,
  output logic [NUM_INT-1:0] int_pending,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] prev_int;
  logic [VW-1:0]      vec;

  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] clr_mask;
  logic [VW-1:0]      sel_vec;
  logic               deliver_hs;

  // Read-only port: the write side is permanently idle.
  assign emem_wr_en   = 1'b0;
  assign emem_wr_data = '0;
  assign emem_wr_size = 8'(1 << ENTRY_SHIFT);

  assign int_pending  = pending;
  assign fsm_state    = state;

  function automatic logic [ADDRW-1:0] entry_addr(input logic [VW-1:0] v);
    return IDT_BASE + (ADDRW'(v) << ENTRY_SHIFT);
  endfunction

  // ---------------------------------------------------------------------------
  // Pending register
  // ---------------------------------------------------------------------------
  assign rise       = interrupt & ~prev_int;
  assign deliver_hs = int_valid & int_ready;
  assign clr_mask   = deliver_hs ? (NUM_INT'(1) << vec) : '0;

  // The OR of rise is applied after the clear, so a new edge on the bit being
  // retired in the same cycle keeps that bit pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_int <= '0;
      pending  <= '0;
    end else begin
      prev_int <= interrupt;
      pending  <= (pending & ~clr_mask) | rise;
    end
  end

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    sel_vec = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pending[i]) sel_vec = VW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch controller. Every handshake output is a flop that changes only on
  // the transition into or out of the state that owns it, so payloads are
  // stable for as long as valid is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      vec           <= '0;
      emem_valid    <= 1'b0;
      emem_address  <= '0;
      emem_dp_ready <= 1'b0;
      int_valid     <= 1'b0;
      int_vector    <= '0;
      int_handler   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // int_enable only gates the start of a fetch; once past here the
          // fetch always runs to delivery.
          if (int_enable && (|pending)) begin
            vec          <= sel_vec;
            emem_address <= entry_addr(sel_vec);
            emem_valid   <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (emem_ready) begin
            emem_valid    <= 1'b0;
            emem_address  <= '0;
            emem_dp_ready <= 1'b1;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (emem_dp_valid) begin
            emem_dp_ready <= 1'b0;
            int_handler   <= emem_dp_read_data;
            int_vector    <= vec;
            int_valid     <= 1'b1;
            state         <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          // The pending clear for vec happens in the pending block on this
          // same edge.
          if (int_ready) begin
            int_valid   <= 1'b0;
            int_vector  <= '0;
            int_handler <= '0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake stability properties
  // ---------------------------------------------------------------------------
  a_req_stable : assert property (@(posedge clk) disable iff (!reset)
    (emem_valid && !emem_ready) |=> (emem_valid && $stable(emem_address)));

  a_int_stable : assert property (@(posedge clk) disable iff (!reset)
    (int_valid && !int_ready) |=>
      (int_valid && $stable(int_vector) && $stable(int_handler)));

endmodule

// File: tb/tb_interrupt_vector_fetch.sv
// -----------------------------------------------------------------------------
// Bench for interrupt_vector_fetch. Inputs are driven 1 time unit after each
// rising edge; a negedge monitor compares the DUT against a transaction-level
// model (pending set as plain bit arithmetic, queue of selected vectors, flags
// for the request/response/delivery phase of the one fetch in flight).
// -----------------------------------------------------------------------------
module tb_interrupt_vector_fetch;

  localparam logic [31:0] IDT_BASE = 32'h0000_0400;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] interrupt;
  logic        int_enable;
  logic        emem_valid;
  logic        emem_ready;
  logic [31:0] emem_address;
  logic        emem_wr_en;
  logic [31:0] emem_wr_data;
  logic [7:0]  emem_wr_size;
  logic        emem_dp_valid;
  logic        emem_dp_ready;
  logic [31:0] emem_dp_read_data;
  logic        int_valid;
  logic        int_ready;
  logic [3:0]  int_vector;
  logic [31:0] int_handler;
  logic [15:0] int_pending;
  logic [1:0]  fsm_state;

  interrupt_vector_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .interrupt         (interrupt),
    .int_enable        (int_enable),
    .emem_valid        (emem_valid),
    .emem_ready        (emem_ready),
    .emem_address      (emem_address),
    .emem_wr_en        (emem_wr_en),
    .emem_wr_data      (emem_wr_data),
    .emem_wr_size      (emem_wr_size),
    .emem_dp_valid     (emem_dp_valid),
    .emem_dp_ready     (emem_dp_ready),
    .emem_dp_read_data (emem_dp_read_data),
    .int_valid         (int_valid),
    .int_ready         (int_ready),
    .int_vector        (int_vector),
    .int_handler       (int_handler),
    .int_pending       (int_pending),
    .fsm_state         (fsm_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] vt [16];          // vector table contents served by the bench
  logic [15:0] m_pend, m_prev;
  logic [3:0]  exp_q[$];         // vectors selected and not yet delivered
  logic [3:0]  dlv_vec_q[$];     // delivered vectors, in order
  logic [31:0] acc_addr_q[$];    // accepted request addresses, in order
  bit          req_out, resp_out, dlv_out;
  int          resp_delay;
  logic [3:0]  resp_idx;
  int          acc_count;

  bit auto_mem, auto_ird, rnd;

  logic [15:0] rise_v, clr_v;
  logic [3:0]  head_v;
  bit          sel_v;

  function automatic logic [3:0] lowest(input logic [15:0] p);
    for (int i = 0; i < 16; i++) if (p[i]) return 4'(i);
    return 4'd0;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_emem_valid", emem_valid, 0);
      check("rst_dp_ready", emem_dp_ready, 0);
      check("rst_int_valid", int_valid, 0);
      check("rst_pending", int_pending, 0);
      check("rst_wr_size", emem_wr_size, 4);
      m_pend = '0; m_prev = '0;
      exp_q.delete();
      req_out = 0; resp_out = 0; dlv_out = 0;
    end else begin
      check("pending", int_pending, m_pend);
      check("emem_valid", emem_valid, req_out);
      check("dp_ready", emem_dp_ready, resp_out);
      check("int_valid", int_valid, dlv_out);
      head_v = (exp_q.size() > 0) ? exp_q[0] : 4'd0;
      if (emem_valid) check("emem_address", emem_address, IDT_BASE + (32'(head_v) << 2));
      if (int_valid) begin
        check("int_vector", int_vector, head_v);
        check("int_handler", int_handler, vt[head_v]);
      end
      // Effects of the coming rising edge.
      rise_v = interrupt & ~m_prev;
      clr_v  = '0;
      sel_v  = !(req_out || resp_out || dlv_out) && int_enable && (m_pend != 0);
      if (dlv_out && int_ready) begin
        clr_v = 16'h1 << head_v;
        void'(exp_q.pop_front());
        dlv_vec_q.push_back(int_vector);
        dlv_out = 0;
      end
      if (resp_out && emem_dp_valid) begin
        resp_out = 0;
        dlv_out  = 1;
      end
      if (req_out && emem_ready) begin
        req_out    = 0;
        resp_out   = 1;
        resp_idx   = head_v;
        resp_delay = rnd ? $urandom_range(0, 3) : 0;
        acc_count++;
        acc_addr_q.push_back(emem_address);
      end
      if (sel_v) begin
        exp_q.push_back(lowest(m_pend));
        req_out = 1;
      end
      m_pend = (m_pend & ~clr_v) | rise_v;
      m_prev = interrupt;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      emem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (resp_out) begin
        if (resp_delay > 0) begin
          resp_delay--;
          emem_dp_valid = 1'b0;
        end else begin
          emem_dp_valid     = 1'b1;
          emem_dp_read_data = vt[resp_idx];
        end
      end else begin
        // Stray read data outside a fetch must be ignored by the DUT.
        emem_dp_valid     = rnd && ($urandom_range(0, 3) == 0);
        emem_dp_read_data = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end
    end
    if (auto_ird) int_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
  endtask

  task automatic drain(input string tag);
    interrupt  = '0;
    int_enable = 1'b1;
    auto_mem   = 1;
    auto_ird   = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_pend == 0 && !req_out && !resp_out && !dlv_out) break;
    end
    check({tag, "_idle"}, {m_pend == 0, req_out, resp_out, dlv_out}, 4'b1000);
    check({tag, "_pending"}, int_pending, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 16; i++) vt[i] = $urandom();
    reset = 0; interrupt = 16'hFFFF; int_enable = 0;
    emem_ready = 0; emem_dp_valid = 0; emem_dp_read_data = 0; int_ready = 0;
    auto_mem = 0; auto_ird = 0; rnd = 0; acc_count = 0;

    // Reset with all lines high.
    repeat (3) tick();
    check("rst_address", emem_address, 0);
    check("rst_wr_en", emem_wr_en, 0);
    check("rst_wr_data", emem_wr_data, 0);
    check("rst_vector", int_vector, 0);
    check("rst_handler", int_handler, 0);
    check("rst_state", fsm_state, 0);
    reset = 1;
    tick();
    check("release_pending", int_pending, 16'hFFFF);
    dlv_vec_q.delete();
    drain("drain_all");
    check("drain_count", dlv_vec_q.size(), 16);
    if (dlv_vec_q.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("drain_order%0d", i), dlv_vec_q[i], i);

    // Single IRQ, zero-wait memory.
    vt[3] = 32'h0000_0040;
    interrupt = 16'h0008;
    tick();
    check("single_pend", int_pending[3], 1);
    check("single_noreq", emem_valid, 0);
    tick();
    check("single_req", emem_valid, 1);
    check("single_addr", emem_address, 32'h0000_040C);
    check("single_wr_en", emem_wr_en, 0);
    check("single_wr_size", emem_wr_size, 4);
    tick();
    check("single_wait", emem_dp_ready, 1);
    check("single_early", int_valid, 0);
    tick();
    check("single_valid", int_valid, 1);
    check("single_vector", int_vector, 3);
    check("single_handler", int_handler, 32'h40);
    tick();
    check("single_done", int_valid, 0);
    check("single_clear", int_pending[3], 0);
    interrupt = '0;
    tick();

    // Priority: 5 and 2 together.
    dlv_vec_q.delete(); acc_addr_q.delete();
    interrupt = 16'h0024;
    for (int i = 0; i < 40 && dlv_vec_q.size() < 2; i++) tick();
    check("prio_count", dlv_vec_q.size(), 2);
    if (dlv_vec_q.size() == 2) begin
      check("prio_first", dlv_vec_q[0], 2);
      check("prio_second", dlv_vec_q[1], 5);
      check("prio_addr0", acc_addr_q[0], 32'h408);
      check("prio_addr1", acc_addr_q[1], 32'h414);
    end
    tick();
    check("prio_pending", int_pending, 0);
    interrupt = '0;
    tick();

    // Stalls on every channel.
    auto_mem = 0; auto_ird = 0;
    emem_ready = 0; emem_dp_valid = 0; int_ready = 0;
    acc_count = 0;
    interrupt = 16'h0080;
    for (int i = 0; i < 10 && !emem_valid; i++) tick();
    check("stall_req_seen", emem_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req_hold", emem_valid, 1);
      check("stall_addr_hold", emem_address, 32'h41C);
    end
    emem_ready = 1;
    tick();
    emem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      check("stall_dp_ready", emem_dp_ready, 1);
      check("stall_no_valid", int_valid, 0);
      tick();
    end
    emem_dp_valid = 1; emem_dp_read_data = vt[7];
    tick();
    emem_dp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_int_hold", int_valid, 1);
      check("stall_vec_hold", int_vector, 7);
      check("stall_hdl_hold", int_handler, vt[7]);
      tick();
    end
    int_ready = 1;
    tick();
    int_ready = 0;
    check("stall_released", int_valid, 0);
    check("stall_one_req", acc_count, 1);
    interrupt = '0;
    tick();

    // Enable gating, then clear/set collision on bit 1.
    int_enable = 0;
    interrupt  = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_no_req", emem_valid, 0);
      check("gate_pending", int_pending[1], 1);
    end
    interrupt  = '0;
    int_enable = 1;
    auto_mem   = 1;
    for (int i = 0; i < 20 && !int_valid; i++) tick();
    check("gate_dlv", int_valid, 1);
    check("gate_vector", int_vector, 1);
    dlv_vec_q.delete();
    int_ready = 1;
    interrupt = 16'h0002;
    tick();
    int_ready = 0;
    check("collide_pending", int_pending[1], 1);
    check("collide_released", int_valid, 0);
    auto_ird = 1;
    for (int i = 0; i < 20 && dlv_vec_q.size() < 2; i++) tick();
    check("collide_count", dlv_vec_q.size(), 2);
    if (dlv_vec_q.size() == 2) check("collide_vector", dlv_vec_q[1], 1);
    interrupt = '0;
    tick(); tick();
    check("collide_cleared", int_pending, 0);

    // Reset while waiting for read data.
    auto_mem = 0; auto_ird = 0;
    emem_ready = 0; emem_dp_valid = 0; int_ready = 0;
    interrupt = 16'h0010;
    for (int i = 0; i < 10 && !emem_valid; i++) tick();
    check("rwait_req", emem_valid, 1);
    emem_ready = 1;
    tick();
    emem_ready = 0;
    check("rwait_waiting", emem_dp_ready, 1);
    interrupt = '0;
    reset = 0;
    #1;
    check("rwait_async_state", fsm_state, 0);
    check("rwait_async_dp", emem_dp_ready, 0);
    emem_dp_valid = 1; emem_dp_read_data = 32'hCAFE_0000;
    tick();
    reset = 1;
    tick(); tick();
    check("rwait_state", fsm_state, 0);
    check("rwait_no_int", int_valid, 0);
    check("rwait_pending", int_pending, 0);
    check("rwait_dp_ready", emem_dp_ready, 0);
    emem_dp_valid = 0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 16; i++) vt[i] = $urandom();
    rnd = 1; auto_mem = 1; auto_ird = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 5) == 0) interrupt = interrupt ^ (16'h1 << $urandom_range(0, 15));
      int_enable = ($urandom_range(0, 4) != 0);
    end
    drain("drain_rand");
    check("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
